gmul_sched: RTL and testbench
=============================

// Module: gmul_sched
// PURPOSE
//  Round-robin scheduler that shares one gmul16 GF(2^16) multiplier between N_REQ requesters.
//  Per-requester valid/ready for requests and responses; operands latched at accept.
//  Sequences the 2-cycle gmul16 protocol (req held 2 cycles, result on rdy).
//  Sits between the crypto/ECC pipeline clients and the shared GF multiply datapath.
// PARAMETERS
//  N_REQ  4                   number of requesters (>=1)
//  GW     max(1,$clog2(N_REQ)) grant index width (derived, localparam)
// PORTS
//  clk         in   1          clock
//  rst         in   1          asynchronous, active-high reset
//  req_valid   in   N_REQ      requester i has an operation pending
//  req_ready   out  N_REQ      one-hot; request i accepted this cycle
//  req_a       in   N_REQ*16   operand a, requester i at [16*i+:16]
//  req_b       in   N_REQ*16   operand b
//  req_m       in   N_REQ*16   reduction polynomial (x^16 term implicit)
//  resp_valid  out  N_REQ      one-hot; result for requester i is on resp_p
//  resp_ready  in   N_REQ      requester i takes result
//  resp_p      out  16         product a*b mod (x^16+m)
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, resp_valid=0, resp_p=0, busy=0, last_grant=N_REQ-1 (req 0 wins first).
//  gmul16 reset port driven by ~rst; rst mid-operation drops pending op and result; no response issued.
//  FSM IDLE/MUL0/MUL1/RESP:
//   IDLE: if |req_valid: pick first valid index after last_grant (wrapping); req_ready[g]=1
//         combinationally; latch a,b,m,g; last_grant<=g; ->MUL0. Else stay.
//   MUL0: core req=1 with latched operands (core captures upper-byte partial) ->MUL1.
//   MUL1: core req=1; core rdy must be 1; resp_p<=core p ->RESP.
//   RESP: resp_valid[g]=1, resp_p stable until resp_ready[g].
//         resp_ready[g]=0: hold RESP (stall; no new accepts).
//         resp_ready[g]=1 and |req_valid: arbitrate same cycle as IDLE, accept ->MUL0.
//         resp_ready[g]=1 and no valid: ->IDLE.
//  Core req low in IDLE and RESP so gmul16 phase returns to 0 between ops.
//  Latency: accept cycle T -> resp_valid at T+3. Max throughput 1 op / 3 cycles with back-to-back.
//  req_ready only asserted in IDLE or accepting RESP; at most one bit set; never for invalid req.
//  Requester deasserting req_valid before accept: legal, simply not granted.
//  Requester granted at RESP-accept may be the same one being answered (fairness via last_grant).
//  resp_ready on non-granted index ignored. Operands/req_* changes after accept have no effect.
//  N_REQ=1: arbitration degenerates to req_valid[0]; GW=1.
//  Arithmetic: carry-less GF(2) only, performed by gmul16; no width extension.
// STRUCTURE
//  gmul_pkg: GMUL_W=16; typedef enum logic[1:0] {GS_IDLE,GS_MUL0,GS_MUL1,GS_RESP} gmul_sched_state_e.
//  Sub-module: gmul16 instance (one). Round-robin pick is a function in this module, not a module.
//  Registers: state, grant idx, a/b/m operand regs, resp_p reg, last_grant.
// TESTING
//  1. Req0 a=0001 b=1234 m=002B at T -> req_ready[0] at T, resp_valid[0], resp_p=1234 at T+3.
//  2. Req1 a=8000 b=0002 m=002B -> resp_p=002B (x^16 reduction); a=0000 b=FFFF -> resp_p=0000.
//  3. All 4 valid continuously, resp_ready=1111 -> grants 0,1,2,3,0 every 3 cycles, none starved.
//  4. resp_ready[g]=0 for 5 cycles -> resp_valid/resp_p held, req_ready=0000 throughout; release -> next grant same cycle.
//  5. rst pulsed in MUL1 -> next cycle all outputs reset values, no resp_valid; next request served normally, req 0 first.
//  6. Assertions: onehot0(req_ready), onehot0(resp_valid), core rdy==1 in MUL1, resp_p stable while stalled.

Source files
------------

// File: rtl/gmul_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gmul_sched_pkg
//  Description : Shared types and helpers for the GF(2^16) multiply scheduler.
//                GMUL_W             - field element width
//                gmul_sched_state_e - scheduler FSM states
//                gf_xtime()         - multiply by x modulo (x^16 + m)
//  Revision    : 1.0 - initial release
// ============================================================================
package gmul_sched_pkg;

    localparam int GMUL_W = 16;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_MUL0 = 2'd1,
        GS_MUL1 = 2'd2,
        GS_RESP = 2'd3
    } gmul_sched_state_e;

    // One carry-less shift. The x^16 term that falls off the top is folded
    // back in as the low-order reduction polynomial m.
    function automatic logic [GMUL_W-1:0] gf_xtime(
        input logic [GMUL_W-1:0] v,
        input logic [GMUL_W-1:0] m
    );
        return {v[GMUL_W-2:0], 1'b0} ^ (v[GMUL_W-1] ? m : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmul_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : gmul_sched_if
//  Description : Requester-side bus of the GF(2^16) multiply scheduler.
//                req_valid/req_ready  per-requester request handshake
//                req_a/req_b/req_m    operands, requester i at [16*i +: 16]
//                resp_valid/resp_ready per-requester response handshake
//                resp_p               product for the requester flagged in resp_valid
//                busy                 scheduler not idle
//                master = requesters, slave = scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
interface gmul_sched_if #(
    parameter int N_REQ = 4
);
    import gmul_sched_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*GMUL_W-1:0] req_a;
    logic [N_REQ*GMUL_W-1:0] req_b;
    logic [N_REQ*GMUL_W-1:0] req_m;
    logic [N_REQ-1:0]        resp_valid;
    logic [N_REQ-1:0]        resp_ready;
    logic [GMUL_W-1:0]       resp_p;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, req_m, resp_ready,
        input  req_ready, resp_valid, resp_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_m, resp_ready,
        output req_ready, resp_valid, resp_p, busy
    );

endinterface
`default_nettype wire

// File: rtl/gmul_sched_gmul16.sv
`default_nettype none
// ============================================================================
//  Module      : gmul16
//  Description : Two-cycle GF(2^16) multiplier, p = a*b mod (x^16 + m).
//                i_req must be held for two cycles with stable operands.
//                Cycle 1 folds in the upper byte of b and stores the partial;
//                cycle 2 finishes the lower byte combinationally and raises
//                o_rdy with o_p valid. Dropping i_req returns the phase to 0.
//  Ports       : clk, rst_n (async active-low), i_req, i_a, i_b, i_m,
//                o_rdy, o_p
//  Revision    : 1.0 - initial release
// ============================================================================
module gmul16
    import gmul_sched_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_req,
    input  wire logic [GMUL_W-1:0] i_a,
    input  wire logic [GMUL_W-1:0] i_b,
    input  wire logic [GMUL_W-1:0] i_m,
    output logic                   o_rdy,
    output logic [GMUL_W-1:0]      o_p
);

    logic              r_phase;
    logic [GMUL_W-1:0] r_partial;
    logic [GMUL_W-1:0] w_hi;
    logic [GMUL_W-1:0] w_lo;

    // Horner over b[15:8], MSB first: w_hi = a * b_hi mod poly.
    always_comb begin
        w_hi = '0;
        for (int i = GMUL_W-1; i >= GMUL_W/2; i--) begin
            w_hi = gf_xtime(w_hi, i_m);
            if (i_b[i]) begin
                w_hi = w_hi ^ i_a;
            end
        end
    end

    // Continue Horner from the stored partial over b[7:0]; the eight extra
    // shifts supply the x^8 weight of the upper-byte partial.
    always_comb begin
        w_lo = r_partial;
        for (int i = GMUL_W/2-1; i >= 0; i--) begin
            w_lo = gf_xtime(w_lo, i_m);
            if (i_b[i]) begin
                w_lo = w_lo ^ i_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= 1'b0;
            r_partial <= '0;
        end else begin
            if (i_req) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_partial <= w_hi;
                end
            end else begin
                r_phase <= 1'b0;
            end
        end
    end

    assign o_rdy = i_req & r_phase;
    assign o_p   = w_lo;

endmodule
`default_nettype wire

// File: rtl/gmul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : gmul_sched
//  Description : Round-robin scheduler sharing one gmul16 between N_REQ
//                requesters. One operation in flight; accept in cycle T gives
//                resp_valid in cycle T+3. A response that is being taken can
//                overlap the next accept, so back-to-back ops run at 1 per 3
//                cycles.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - gmul_sched_if.slave (requests, responses, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module gmul_sched
    import gmul_sched_pkg::*;
#(
    parameter int N_REQ = 4
)(
    input  wire logic   clk,
    input  wire logic   rst,
    gmul_sched_if.slave bus
);

    localparam int            GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [GW-1:0] C_LAST_INIT = GW'(N_REQ - 1);

    // First valid index strictly after 'last', wrapping. Caller guarantees at
    // least one valid bit when the result is used.
    function automatic logic [GW-1:0] rr_pick(
        input logic [N_REQ-1:0] valid,
        input logic [GW-1:0]    last
    );
        logic [GW-1:0] pick;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (int'(last) + k) % N_REQ;
            if (!found && valid[j]) begin
                pick  = GW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    gmul_sched_state_e r_state;
    gmul_sched_state_e w_next_state;

    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     r_last_grant;
    logic [GMUL_W-1:0] r_a;
    logic [GMUL_W-1:0] r_b;
    logic [GMUL_W-1:0] r_m;
    logic [GMUL_W-1:0] r_resp_p;

    logic              w_any_valid;
    logic [GW-1:0]     w_pick;
    logic [N_REQ-1:0]  w_pick_oh;
    logic [N_REQ-1:0]  w_grant_oh;
    logic              w_resp_taken;
    logic              w_accept;
    logic              w_core_req;
    logic              w_core_rdy;
    logic [GMUL_W-1:0] w_core_p;
    logic [GMUL_W-1:0] w_sel_a;
    logic [GMUL_W-1:0] w_sel_b;
    logic [GMUL_W-1:0] w_sel_m;

    assign w_any_valid  = |bus.req_valid;
    assign w_pick       = rr_pick(bus.req_valid, r_last_grant);
    assign w_resp_taken = bus.resp_ready[r_grant];

    always_comb begin
        w_pick_oh  = '0;
        w_grant_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pick_oh[i]  = (w_pick == GW'(i));
            w_grant_oh[i] = (r_grant == GW'(i));
        end
    end

    always_comb begin
        w_sel_a = bus.req_a[int'(w_pick)*GMUL_W +: GMUL_W];
        w_sel_b = bus.req_b[int'(w_pick)*GMUL_W +: GMUL_W];
        w_sel_m = bus.req_m[int'(w_pick)*GMUL_W +: GMUL_W];
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= GS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            GS_IDLE: begin
                if (w_accept) begin
                    w_next_state = GS_MUL0;
                end
            end
            GS_MUL0: w_next_state = GS_MUL1;
            GS_MUL1: w_next_state = GS_RESP;
            GS_RESP: begin
                if (w_resp_taken) begin
                    w_next_state = w_accept ? GS_MUL0 : GS_IDLE;
                end
            end
            default: w_next_state = GS_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // A stalled response blocks new accepts. req_ready is forced low while
    // rst is asserted so the reset state of every output is quiet even when
    // requests are pending.
    always_comb begin
        w_accept   = 1'b0;
        w_core_req = 1'b0;
        case (r_state)
            GS_IDLE: w_accept   = w_any_valid;
            GS_MUL0: w_core_req = 1'b1;
            GS_MUL1: w_core_req = 1'b1;
            GS_RESP: w_accept   = w_any_valid & w_resp_taken;
            default: ;
        endcase
        if (rst) begin
            w_accept = 1'b0;
        end
    end

    assign bus.req_ready  = w_accept ? w_pick_oh : '0;
    assign bus.resp_valid = (r_state == GS_RESP) ? w_grant_oh : '0;
    assign bus.resp_p     = r_resp_p;
    assign bus.busy       = (r_state != GS_IDLE);

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= C_LAST_INIT;
            r_a          <= '0;
            r_b          <= '0;
            r_m          <= '0;
            r_resp_p     <= '0;
        end else begin
            if (w_accept) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_m          <= w_sel_m;
            end
            if ((r_state == GS_MUL1) && w_core_rdy) begin
                r_resp_p <= w_core_p;
            end
        end
    end

    // Core request is low in IDLE and RESP so its phase is back at 0 before
    // every new operation.
    gmul16 u_gmul16 (
        .clk   (clk),
        .rst_n (~rst),
        .i_req (w_core_req),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_m   (r_m),
        .o_rdy (w_core_rdy),
        .o_p   (w_core_p)
    );

endmodule
`default_nettype wire

// File: tb/tb_gmul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmul_sched
//  Description : Self-checking bench for gmul_sched (N_REQ=4). A transaction
//                level model predicts grants, response timing and products;
//                directed sequences add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmul_sched;
    import gmul_sched_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gmul_sched_if #(.N_REQ(N)) bus ();

    gmul_sched #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // LSB-first shift-and-add carry-less product modulo x^16 + m.
    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] m);
        logic [15:0] p;
        logic [15:0] aa;
        logic        c;
        p  = '0;
        aa = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) p = p ^ aa;
            c  = aa[15];
            aa = aa << 1;
            if (c) aa = aa ^ m;
        end
        return p;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_next(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------------
    // Model: one operation outstanding, response visible from m_rc onwards.
    // ------------------------------------------------------------------------
    bit          mon_on = 1'b0;
    bit          m_pend = 1'b0;
    int          m_who  = 0;
    int          m_rc   = 0;
    int          m_last = N - 1;
    logic [15:0] m_prod = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst) begin
                chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
                chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
                chk("rst_busy",       32'(bus.busy),       32'd0);
                chk("rst_resp_p",     32'(bus.resp_p),     32'd0);
                m_pend = 1'b0;
                m_last = N - 1;
            end else begin
                logic [N-1:0] erv;
                logic [N-1:0] err;
                bit           can_acc;
                int           w;
                erv = (m_pend && cyc >= m_rc) ? onehot(m_who) : '0;
                can_acc = !m_pend || ((erv != 0) && bus.resp_ready[m_who]);
                w = rr_next(bus.req_valid, m_last);
                err = (can_acc && w >= 0) ? onehot(w) : '0;
                chk("req_ready",  32'(bus.req_ready),  32'(err));
                chk("resp_valid", 32'(bus.resp_valid), 32'(erv));
                chk("busy",       32'(bus.busy),       32'(m_pend));
                if (erv != 0) chk("resp_p", 32'(bus.resp_p), 32'(m_prod));
                if (m_pend && cyc == m_rc - 1) chk("core_rdy_mul1", 32'(dut.w_core_rdy), 32'd1);
                if ((erv != 0) && bus.resp_ready[m_who]) m_pend = 1'b0;
                if (err != 0) begin
                    m_pend = 1'b1;
                    m_who  = w;
                    m_rc   = cyc + 3;
                    m_last = w;
                    m_prod = gf_mul(bus.req_a[16*w +: 16], bus.req_b[16*w +: 16],
                                    bus.req_m[16*w +: 16]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] m);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
        bus.req_m[16*i +: 16] = m;
    endtask

    task automatic run_one(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] m, input logic [15:0] exp);
        set_op(idx, a, b, m);
        bus.req_valid = onehot(idx);
        @(negedge clk);
        chk("lit_accept", 32'(bus.req_ready), 32'(onehot(idx)));
        step();
        bus.req_valid = '0;
        step();
        step();
        @(negedge clk);
        chk("lit_resp_valid", 32'(bus.resp_valid), 32'(onehot(idx)));
        chk("lit_resp_p",     32'(bus.resp_p),     32'(exp));
        step();
        step();
    endtask

    int g_idx [5];
    int g_cyc [5];
    int ng;
    int hold_g;
    logic [15:0] hold_p;
    bit found;

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_m      = '0;
        bus.resp_ready = '1;
        mon_on = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Single operations, pinned products.
        run_one(0, 16'h0001, 16'h1234, 16'h002B, 16'h1234);
        run_one(1, 16'h0000, 16'hFFFF, 16'h002B, 16'h0000);
        run_one(1, 16'h8000, 16'h0002, 16'h002B, 16'h002B);

        // Reset while the core is in its second cycle.
        set_op(0, 16'h0003, 16'h0005, 16'h002B);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_rst_resp_p", 32'(bus.resp_p), 32'd0);
        chk("lit_rst_busy",   32'(bus.busy),   32'd0);
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("lit_no_resp_after_rst", 32'(bus.resp_valid), 32'd0);

        // All requesters continuously valid: rotation from reset starts at 0.
        for (int i = 0; i < N; i++) set_op(i, 16'(16'h1111 * (i + 1)), 16'(16'h0F0F ^ i), 16'h002B);
        bus.req_valid = '1;
        ng = 0;
        for (int k = 0; k < 30 && ng < 5; k++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                for (int j = 0; j < N; j++) if (bus.req_ready[j]) g_idx[ng] = j;
                g_cyc[ng] = cyc;
                ng++;
            end
            step();
        end
        chk("lit_grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < ng; i++) begin
            chk("lit_grant_order", 32'(g_idx[i]), 32'(i % N));
            if (i > 0) chk("lit_grant_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
        end

        // Stall a response for five cycles, then release.
        bus.resp_ready = '0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.resp_valid != 0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("lit_stall_resp_seen", 32'(found), 32'd1);
        hold_g = 0;
        for (int j = 0; j < N; j++) if (bus.resp_valid[j]) hold_g = j;
        hold_p = bus.resp_p;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                step();
                @(negedge clk);
            end
            chk("lit_stall_resp_valid", 32'(bus.resp_valid), 32'(onehot(hold_g)));
            chk("lit_stall_resp_p",     32'(bus.resp_p),     32'(hold_p));
            chk("lit_stall_req_ready",  32'(bus.req_ready),  32'd0);
        end
        step();
        bus.resp_ready = '1;
        @(negedge clk);
        chk("lit_release_grant", 32'(bus.req_ready), 32'(onehot((hold_g + 1) % N)));
        step();
        bus.req_valid = '0;
        repeat (8) step();
        chk("lit_drain_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
